// File: rtl/sram_arbiter.sv
// Arbiter/sequencer sharing one synchronous-read SRAM between the Z80 bus and
// the video scanout fetcher. Video wins ties unless the CPU has been starved.
module sram_arbiter #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 8,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_wait_n,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              vid_valid,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_d_wr,
  input  logic [DATA_W-1:0] sram_d_rd,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ACC_CPU  = 3'd1,
    S_ACC_VID  = 3'd2,
    S_DONE_CPU = 3'd3,
    S_DONE_VID = 3'd4
  } state_e;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [3:0] STARVE_SAT = 4'd15;
  localparam logic [1:0] GNT_NONE   = 2'b00;
  localparam logic [1:0] GNT_VID    = 2'b01;
  localparam logic [1:0] GNT_CPU    = 2'b10;

  state_e              state_q, state_d;
  logic [3:0]          starve_q, starve_d;
  logic [ADDR_W-1:0]   sram_a_q, sram_a_d;
  logic [DATA_W-1:0]   sram_d_wr_q, sram_d_wr_d;
  logic                oe_n_q, oe_n_d;
  logic                we_n_q, we_n_d;
  logic                cpu_ack_q, cpu_ack_d;
  logic                vid_valid_q, vid_valid_d;
  logic                cpu_rd_q, cpu_rd_d;
  logic [DATA_W-1:0]   cpu_hold_q, cpu_hold_d;
  logic [DATA_W-1:0]   vid_hold_q, vid_hold_d;
  logic                arb_pt_s;
  logic                cpu_pend_s;
  logic                vid_pend_s;
  logic [1:0]          grant_s;

  // Priority decision: video first, CPU once it has lost STARVE_MAX times in a row.
  function automatic logic [1:0] arb_grant(input logic cpu_p, input logic vid_p,
                                           input logic [3:0] starve);
    logic [1:0] g;
    if (cpu_p && (!vid_p || (starve >= STARVE_LIM))) begin
      g = GNT_CPU;
    end else if (vid_p) begin
      g = GNT_VID;
    end else begin
      g = GNT_NONE;
    end
    return g;
  endfunction

  // Next-state, arbitration and strobe decode.
  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    sram_a_d    = sram_a_q;
    sram_d_wr_d = sram_d_wr_q;
    oe_n_d      = 1'b1;
    we_n_d      = 1'b1;
    cpu_ack_d   = 1'b0;
    vid_valid_d = 1'b0;
    cpu_rd_d    = cpu_rd_q;
    cpu_hold_d  = cpu_hold_q;
    vid_hold_d  = vid_hold_q;
    arb_pt_s    = 1'b0;
    cpu_pend_s  = 1'b0;
    vid_pend_s  = 1'b0;

    // A DONE state arbitrates with its own requester masked out: its req is still high.
    case (state_q)
      S_IDLE: begin
        arb_pt_s   = 1'b1;
        cpu_pend_s = cpu_req;
        vid_pend_s = vid_req;
      end
      S_ACC_CPU: begin
        state_d   = S_DONE_CPU;
        cpu_ack_d = 1'b1;
      end
      S_ACC_VID: begin
        state_d     = S_DONE_VID;
        vid_valid_d = 1'b1;
      end
      S_DONE_CPU: begin
        arb_pt_s   = 1'b1;
        vid_pend_s = vid_req;
        if (cpu_rd_q) begin
          cpu_hold_d = sram_d_rd;
        end else begin
          cpu_hold_d = cpu_hold_q;
        end
      end
      S_DONE_VID: begin
        arb_pt_s   = 1'b1;
        cpu_pend_s = cpu_req;
        vid_hold_d = sram_d_rd;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    grant_s = arb_grant(cpu_pend_s, vid_pend_s, starve_q);

    if (arb_pt_s) begin
      if (grant_s == GNT_CPU) begin
        state_d  = S_ACC_CPU;
        sram_a_d = cpu_addr;
        cpu_rd_d = ~cpu_we;
        oe_n_d   = cpu_we;
        we_n_d   = ~cpu_we;
        if (cpu_we) begin
          sram_d_wr_d = cpu_wdata;
        end else begin
          sram_d_wr_d = sram_d_wr_q;
        end
      end else if (grant_s == GNT_VID) begin
        state_d  = S_ACC_VID;
        sram_a_d = vid_addr;
        oe_n_d   = 1'b0;
      end else begin
        state_d = S_IDLE;
      end

      if (!cpu_req || (grant_s == GNT_CPU)) begin
        starve_d = 4'd0;
      end else if ((grant_s == GNT_VID) && cpu_pend_s && (starve_q != STARVE_SAT)) begin
        starve_d = starve_q + 4'd1;
      end else begin
        starve_d = starve_q;
      end
    end else begin
      starve_d = starve_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      starve_q    <= 4'd0;
      sram_a_q    <= '0;
      sram_d_wr_q <= '0;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      cpu_ack_q   <= 1'b0;
      vid_valid_q <= 1'b0;
      cpu_rd_q    <= 1'b0;
      cpu_hold_q  <= '0;
      vid_hold_q  <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      sram_a_q    <= sram_a_d;
      sram_d_wr_q <= sram_d_wr_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      cpu_ack_q   <= cpu_ack_d;
      vid_valid_q <= vid_valid_d;
      cpu_rd_q    <= cpu_rd_d;
      cpu_hold_q  <= cpu_hold_d;
      vid_hold_q  <= vid_hold_d;
    end
  end

  // Read data arrives from the SRAM during the completion cycle itself.
  assign cpu_rdata  = (cpu_ack_q && cpu_rd_q) ? sram_d_rd : cpu_hold_q;
  assign vid_rdata  = vid_valid_q ? sram_d_rd : vid_hold_q;
  assign cpu_ack    = cpu_ack_q;
  assign vid_valid  = vid_valid_q;
  assign cpu_wait_n = ~(cpu_req & ~cpu_ack_q);
  assign sram_a     = sram_a_q;
  assign sram_d_wr  = sram_d_wr_q;
  assign sram_oe_n  = oe_n_q;
  assign sram_we_n  = we_n_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: behavioural SRAM device, transaction-schedule model
// checked every cycle, plus directed scenarios with hand-computed expectations.
module tb_sram_arbiter;
  localparam int AW = 15;
  localparam int DW = 8;
  localparam int SM = 3;

  logic          clk;
  logic          reset;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          cpu_ack, cpu_wait_n;
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic [DW-1:0] vid_rdata;
  logic          vid_valid;
  logic [AW-1:0] sram_a;
  logic [DW-1:0] sram_d_wr, sram_d_rd;
  logic          sram_oe_n, sram_we_n;

  int n_cmp = 0;
  int n_bad = 0;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_wait_n(cpu_wait_n),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_rdata(vid_rdata), .vid_valid(vid_valid),
    .sram_a(sram_a), .sram_d_wr(sram_d_wr), .sram_d_rd(sram_d_rd),
    .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read SRAM: data appears the cycle after address + oe_n.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rd_q = '0;
  always @(posedge clk) begin
    if (!sram_we_n) mem[sram_a] <= sram_d_wr;
    if (!sram_oe_n) rd_q <= mem[sram_a];
  end
  assign sram_d_rd = rd_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: per-cycle schedule of grants (access cycle, completion cycle, next decision).
  int            cyc = 0;
  bit            m_live = 1'b0;
  int            m_arb, m_acc = -10, m_done = -10;
  int            m_excl;       // 0 none, 1 cpu, 2 video
  int            m_starve;
  bit            m_acc_we, m_done_cpu, m_done_rd;
  logic [DW-1:0] m_done_data, m_cpu_hold, m_vid_hold, m_dwr;
  logic [AW-1:0] m_a;
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];

  initial begin
    bit cpu_p, vid_p, g_cpu, g_vid;
    forever begin
      @(posedge clk);
      if (m_live && (m_done == cyc) && m_done_rd) begin
        if (m_done_cpu) m_cpu_hold = m_done_data;
        else            m_vid_hold = m_done_data;
      end
      if (reset) begin
        m_live = 1'b1; m_acc = -10; m_done = -10; m_arb = cyc + 1; m_excl = 0;
        m_starve = 0; m_a = '0; m_dwr = '0; m_cpu_hold = '0; m_vid_hold = '0;
      end else if (m_live && (m_arb == cyc)) begin
        cpu_p = cpu_req && (m_excl != 1);
        vid_p = vid_req && (m_excl != 2);
        g_cpu = cpu_p && (!vid_p || (m_starve >= SM));
        g_vid = vid_p && !g_cpu;
        if (!cpu_req || g_cpu) m_starve = 0;
        else if (g_vid && cpu_p && (m_starve < 15)) m_starve++;
        if (g_cpu || g_vid) begin
          m_acc = cyc + 1; m_done = cyc + 2; m_arb = cyc + 2;
          m_excl = g_cpu ? 1 : 2;
          m_done_cpu = g_cpu;
          if (g_cpu) begin
            m_a = cpu_addr; m_acc_we = cpu_we; m_done_rd = !cpu_we;
            if (cpu_we) begin
              m_dwr = cpu_wdata;
              ref_mem[cpu_addr] = cpu_wdata;
            end else begin
              m_done_data = ref_mem[cpu_addr];
            end
          end else begin
            m_a = vid_addr; m_acc_we = 1'b0; m_done_rd = 1'b1;
            m_done_data = ref_mem[vid_addr];
          end
        end else begin
          m_arb = cyc + 1;
          m_excl = 0;
        end
      end
      cyc++;
    end
  end

  // Compare process: every cycle once reset has been seen.
  initial begin
    logic e_ack, e_vv, e_oe_n, e_we_n, e_wait_n;
    logic [DW-1:0] e_crd, e_vrd;
    forever begin
      @(negedge clk);
      if (m_live) begin
        e_ack    = (m_done == cyc) && m_done_cpu;
        e_vv     = (m_done == cyc) && !m_done_cpu;
        e_oe_n   = !((m_acc == cyc) && !m_acc_we);
        e_we_n   = !((m_acc == cyc) && m_acc_we);
        e_crd    = (e_ack && m_done_rd) ? m_done_data : m_cpu_hold;
        e_vrd    = e_vv ? m_done_data : m_vid_hold;
        e_wait_n = !(cpu_req && !e_ack);
        chk("cyc_cpu_ack", 32'(cpu_ack), 32'(e_ack));
        chk("cyc_vid_valid", 32'(vid_valid), 32'(e_vv));
        chk("cyc_oe_n", 32'(sram_oe_n), 32'(e_oe_n));
        chk("cyc_we_n", 32'(sram_we_n), 32'(e_we_n));
        chk("cyc_sram_a", 32'(sram_a), 32'(m_a));
        chk("cyc_sram_d_wr", 32'(sram_d_wr), 32'(m_dwr));
        chk("cyc_cpu_rdata", 32'(cpu_rdata), 32'(e_crd));
        chk("cyc_vid_rdata", 32'(vid_rdata), 32'(e_vrd));
        chk("cyc_wait_n", 32'(cpu_wait_n), 32'(e_wait_n));
      end
    end
  end

  int            r_c_at, r_v_at, r_we_low, r_wait_low, r_v_before;
  logic [DW-1:0] r_c_dat, r_v_dat;

  // Starts at posedge+1 and returns at posedge+1 with both requests dropped.
  task automatic run_txn(input logic c_en, input logic c_we, input logic [AW-1:0] c_a,
                         input logic [DW-1:0] c_d, input logic v_en, input logic [AW-1:0] v_a,
                         input logic v_keep, input int n_cyc);
    int vcnt;
    vcnt = 0; r_c_at = -1; r_v_at = -1; r_we_low = 0; r_wait_low = 0; r_v_before = -1;
    r_c_dat = '0; r_v_dat = '0;
    cpu_req = c_en; cpu_we = c_we; cpu_addr = c_a; cpu_wdata = c_d;
    vid_req = v_en; vid_addr = v_a;
    for (int i = 0; i < n_cyc; i++) begin
      @(negedge clk);
      if (cpu_req && !cpu_wait_n) r_wait_low++;
      if (!sram_we_n) r_we_low++;
      if (cpu_ack && (r_c_at < 0)) begin
        r_c_at = i; r_c_dat = cpu_rdata; r_v_before = vcnt;
      end
      if (vid_valid) begin
        if (r_v_at < 0) begin
          r_v_at = i; r_v_dat = vid_rdata;
        end
        vcnt++;
      end
      @(posedge clk); #1;
      if (r_c_at >= 0) cpu_req = 1'b0;
      if ((r_v_at >= 0) && !v_keep) vid_req = 1'b0;
    end
    cpu_req = 1'b0;
    vid_req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int a1, a2, n_ack;
    logic [DW-1:0] d1, d2;
    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    vid_req = 1'b0; vid_addr = '0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("rst_oe_n", 32'(sram_oe_n), 32'd1);
    chk("rst_we_n", 32'(sram_we_n), 32'd1);
    chk("rst_sram_a", 32'(sram_a), 32'd0);
    chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    chk("rst_vid_valid", 32'(vid_valid), 32'd0);
    chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    chk("rst_vid_rdata", 32'(vid_rdata), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle(1);

    // Preload video location through the CPU port.
    run_txn(1'b1, 1'b1, 15'h0100, 8'h3C, 1'b0, 15'h0000, 1'b0, 6);
    chk("pre_ack_at", 32'(r_c_at), 32'd2);
    idle(2);

    run_txn(1'b1, 1'b1, 15'h1234, 8'hA5, 1'b0, 15'h0000, 1'b0, 6);
    chk("wr_ack_at", 32'(r_c_at), 32'd2);
    chk("wr_we_low_cycles", 32'(r_we_low), 32'd1);
    chk("wr_wait_low_cycles", 32'(r_wait_low), 32'd2);
    idle(2);

    run_txn(1'b1, 1'b0, 15'h1234, 8'h00, 1'b0, 15'h0000, 1'b0, 6);
    chk("rd_ack_at", 32'(r_c_at), 32'd2);
    chk("rd_data", 32'(r_c_dat), 32'hA5);
    chk("rd_wait_low_cycles", 32'(r_wait_low), 32'd2);
    chk("rd_we_low_cycles", 32'(r_we_low), 32'd0);
    idle(2);

    run_txn(1'b0, 1'b0, 15'h0000, 8'h00, 1'b1, 15'h0100, 1'b0, 6);
    chk("vid_valid_at", 32'(r_v_at), 32'd2);
    chk("vid_data", 32'(r_v_dat), 32'h3C);
    @(negedge clk);
    chk("vid_hold_data", 32'(vid_rdata), 32'h3C);
    chk("vid_hold_valid", 32'(vid_valid), 32'd0);
    @(posedge clk); #1;
    idle(2);

    run_txn(1'b1, 1'b0, 15'h1234, 8'h00, 1'b1, 15'h0100, 1'b0, 8);
    chk("both_vid_at", 32'(r_v_at), 32'd2);
    chk("both_cpu_at", 32'(r_c_at), 32'd4);
    chk("both_cpu_data", 32'(r_c_dat), 32'hA5);
    chk("both_vid_data", 32'(r_v_dat), 32'h3C);
    chk("both_wait_low_cycles", 32'(r_wait_low), 32'd4);
    idle(2);

    run_txn(1'b1, 1'b0, 15'h1234, 8'h00, 1'b1, 15'h0100, 1'b1, 12);
    chk("starve_vid_at", 32'(r_v_at), 32'd2);
    chk("starve_cpu_at", 32'(r_c_at), 32'd4);
    chk("starve_vid_before_cpu", 32'(r_v_before), 32'd1);
    chk("starve_bound", 32'(r_v_before >= 0 && r_v_before <= SM), 32'd1);
    idle(4);

    // Same requester held across its ack with a new address.
    a1 = -1; a2 = -1; d1 = '0; d2 = '0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h1234;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (cpu_ack) begin
        if (a1 < 0) begin
          a1 = i; d1 = cpu_rdata;
        end else if (a2 < 0) begin
          a2 = i; d2 = cpu_rdata;
        end
      end
      @(posedge clk); #1;
      if (a2 >= 0) cpu_req = 1'b0;
      else if (a1 >= 0) cpu_addr = 15'h0100;
    end
    cpu_req = 1'b0;
    chk("b2b_first_at", 32'(a1), 32'd2);
    chk("b2b_second_at", 32'(a2), 32'd5);
    chk("b2b_first_data", 32'(d1), 32'hA5);
    chk("b2b_second_data", 32'(d2), 32'h3C);
    idle(2);

    // Reset asserted for two edges while a CPU write is in its access cycle.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0200; cpu_wdata = 8'h77;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rstmid_in_acc_we_n", 32'(sram_we_n), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("rstmid_we_n", 32'(sram_we_n), 32'd1);
    chk("rstmid_oe_n", 32'(sram_oe_n), 32'd1);
    chk("rstmid_cpu_ack", 32'(cpu_ack), 32'd0);
    chk("rstmid_sram_a", 32'(sram_a), 32'd0);
    chk("rstmid_wait_n", 32'(cpu_wait_n), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    cpu_req = 1'b0;
    n_ack = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (cpu_ack) n_ack++;
    end
    chk("rstmid_no_ack", 32'(n_ack), 32'd0);

    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
